// File: rtl/seq_mult16_wb.sv
`default_nettype none
// ============================================================================
// seq_mult16_wb : sequential shift-add multiplier, signed/unsigned, with a
//                 two-cycle write-back of the double-width product.
// Revision 1.0
// ============================================================================
module seq_mult16_wb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             reg_w,
    output logic             reg_sel,
    output logic [WIDTH-1:0] reg_din
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WB_LO = 2'd2,
        S_WB_HI = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_d, done_d, reg_w_d, reg_sel_d;
    logic [WIDTH-1:0]   reg_din_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;

    // Magnitudes fit in WIDTH unsigned bits, so the most negative value maps to 2^(WIDTH-1).
    assign mag_a = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Accumulator holds {partial product, remaining multiplier}; both shift right each step.
    assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign step = {sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        reg_w_d   = 1'b0;
        reg_sel_d = 1'b0;
        reg_din_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    mcand_d = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    cnt_d   = '0;
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d   = S_WB_LO;
                    cnt_d     = '0;
                    acc_d     = neg_q ? (~step + 1'b1) : step;
                    reg_w_d   = 1'b1;
                    reg_din_d = acc_d[WIDTH-1:0];
                end
            end
            S_WB_LO: begin
                state_d   = S_WB_HI;
                reg_w_d   = 1'b1;
                reg_sel_d = 1'b1;
                reg_din_d = acc_q[2*WIDTH-1:WIDTH];
            end
            S_WB_HI: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            reg_w   <= 1'b0;
            reg_sel <= 1'b0;
            reg_din <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy    <= busy_d;
            done    <= done_d;
            reg_w   <= reg_w_d;
            reg_sel <= reg_sel_d;
            reg_din <= reg_din_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult16_wb.sv
`default_nettype none
// Randomized and directed checks of seq_mult16_wb against an arithmetic product model.
module tb_seq_mult16_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, reg_w, reg_sel;
    logic [15:0] reg_din;

    int n_checks = 0;
    int n_pass   = 0;

    seq_mult16_wb #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy), .done(done), .reg_w(reg_w),
        .reg_sel(reg_sel), .reg_din(reg_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input bit s);
        longint p, q, r;
        p = s ? longint'($signed(x)) : longint'(x);
        q = s ? longint'($signed(y)) : longint'(y);
        r = p * q;
        return r[31:0];
    endfunction

    function automatic logic [19:0] outs();
        return {busy, done, reg_w, reg_sel, reg_din};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] x, input logic [15:0] y, input bit s);
        a = x; b = y; signed_op = s; start = 1'b1;
    endtask

    // Follows one operation launched just before the next edge; optionally
    // injects a stray start at CALC edge 'glitch' and chains a new start in the done cycle.
    task automatic follow(input string tag, input logic [15:0] x, input logic [15:0] y, input bit s,
                          input int glitch, input bit chain,
                          input logic [15:0] nx, input logic [15:0] ny, input bit ns);
        logic [31:0] exp;
        int bad;
        exp = model(x, y, s);
        bad = 0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (outs() !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) bad++;
            if (k == glitch - 1) begin
                start = 1'b1; a = 16'($urandom); b = 16'($urandom); signed_op = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_calc"}, 32'(bad), 32'd0);
        check({tag, "_wblo"}, 32'(outs()), 32'({1'b1, 1'b0, 1'b1, 1'b0, exp[15:0]}));
        tick();
        check({tag, "_wbhi"}, 32'(outs()), 32'({1'b1, 1'b0, 1'b1, 1'b1, exp[31:16]}));
        tick();
        check({tag, "_done"}, 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
        if (chain) begin
            launch(nx, ny, ns);
        end else begin
            tick();
            check({tag, "_idle"}, 32'(outs()), 32'd0);
        end
    endtask

    task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y, input bit s);
        launch(x, y, s);
        follow(tag, x, y, s, -1, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // Aborts an operation with rst after 'edges' edges past start, then watches for stray pulses.
    task automatic abort(input string tag, input int edges);
        int stray;
        launch(16'h1234, 16'h5678, 1'b0);
        tick();
        start = 1'b0;
        for (int k = 1; k < edges; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({tag, "_after_rst"}, 32'(outs()), 32'd0);
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            if (reg_w || done || busy) stray++;
            tick();
        end
        check({tag, "_no_pulse"}, 32'(stray), 32'd0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("reset_state", 32'(outs()), 32'd0);

        op("u3x5",      16'h0003, 16'h0005, 1'b0);
        op("uFFFFxFFFF",16'hFFFF, 16'hFFFF, 1'b0);
        op("s8000x1",   16'h8000, 16'h0001, 1'b1);
        op("sFFFFxFFFF",16'hFFFF, 16'hFFFF, 1'b1);
        op("s8000x8000",16'h8000, 16'h8000, 1'b1);
        op("u0xFFFF",   16'h0000, 16'hFFFF, 1'b0);
        op("sFFFFx0",   16'hFFFF, 16'h0000, 1'b1);

        abort("rst_calc8", 8);
        op("after_abort", 16'h00C8, 16'hFF38, 1'b1);
        abort("rst_wblo", 17);

        launch(16'h0123, 16'h0045, 1'b0);
        follow("glitch5", 16'h0123, 16'h0045, 1'b0, 5, 1'b0, 16'h0, 16'h0, 1'b0);

        launch(16'hF00D, 16'h7FFF, 1'b1);
        follow("chain1", 16'hF00D, 16'h7FFF, 1'b1, -1, 1'b1, 16'hABCD, 16'h1357, 1'b0);
        follow("chain2", 16'hABCD, 16'h1357, 1'b0, -1, 1'b0, 16'h0, 16'h0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] x, y;
            bit s;
            x = pick(); y = pick(); s = 1'($urandom);
            op($sformatf("rnd%0d", i), x, y, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
